// File: rtl/mms_stream.sv
// mms_stream: frame-based running maximum/minimum over a valid/ready sample stream.
// Each frame of FRAME_LEN accepted samples yields one result, held until the consumer
// takes it. select (0 = max, 1 = min) is captured with the first sample of a frame.
// Optional feature: define MMS_ARGIDX_EN to add the result_idx port, which reports the
// 0-based position of the winning sample. Ties keep the earlier sample.
module mms_stream #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int SIGNED    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef MMS_ARGIDX_EN
  ,output logic [$clog2(FRAME_LEN)-1:0] result_idx
`endif
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   count_r;
  logic [WIDTH-1:0]   best_r;
  logic               mode_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               accept_s;
  logic               last_s;
  logic               better_s;
`ifdef MMS_ARGIDX_EN
  logic [IDX_W-1:0]   best_idx_r;
`endif

  // Strict "better" test: candidate must beat the current best, so ties keep the earlier sample.
  function automatic logic is_better(input logic [WIDTH-1:0] cand,
                                     input logic [WIDTH-1:0] cur,
                                     input logic             min_mode);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = ($signed(cand) > $signed(cur));
      lt = ($signed(cand) < $signed(cur));
    end else begin
      gt = (cand > cur);
      lt = (cand < cur);
    end
    return min_mode ? lt : gt;
  endfunction

  assign accept_s = in_valid & in_ready_r;
  assign last_s   = ((count_r + CNT_W'(1)) == CNT_W'(FRAME_LEN));
  assign better_s = is_better(in_data, best_r, mode_r);

  // Next-state decode: IDLE -> RUN on first sample, RUN -> HOLD on the FRAME_LEN-th, HOLD -> IDLE on out_ready.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (accept_s && last_s) state_s = HOLD;
        else                    state_s = RUN;
      end
      HOLD: begin
        if (out_ready) state_s = IDLE;
        else           state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != HOLD);
      out_valid_r <= (state_s == HOLD);
    end
  end

  // Frame datapath: sample counter, running best value and the mode latched at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      best_r  <= '0;
      mode_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            best_r  <= in_data;
            mode_r  <= select;
            count_r <= CNT_W'(1);
          end else begin
            count_r <= count_r;
          end
        end
        RUN: begin
          if (accept_s) begin
            count_r <= count_r + CNT_W'(1);
            if (better_s) best_r <= in_data;
            else          best_r <= best_r;
          end else begin
            count_r <= count_r;
          end
        end
        HOLD: begin
          if (out_ready) count_r <= '0;
          else           count_r <= count_r;
        end
        default: count_r <= '0;
      endcase
    end
  end

`ifdef MMS_ARGIDX_EN
  // Winning-sample position: 0 on the first sample, current count when a later sample wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_idx_r <= '0;
    end else if ((state_r == IDLE) && accept_s) begin
      best_idx_r <= '0;
    end else if ((state_r == RUN) && accept_s && better_s) begin
      best_idx_r <= count_r[IDX_W-1:0];
    end else begin
      best_idx_r <= best_idx_r;
    end
  end

  assign result_idx = best_idx_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = best_r;

endmodule

// File: doc/mms_stream.md
MMS_STREAM -- requirements
Module: mms_stream

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each sample and of the result.
REQ-002 Parameter FRAME_LEN, default 4: samples per frame. Legal range 2..1024.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port select  input  1: 0 = maximum, 1 = minimum. Sampled with the first sample of a frame.
REQ-007 Port in_valid  input  1: sample present on in_data.
REQ-008 Port in_data  input  WIDTH: sample value.
REQ-009 Port in_ready  output  1: block accepts a sample this cycle.
REQ-010 Port out_valid  output  1: result fields valid.
REQ-011 Port out_ready  input  1: consumer accepts the result.
REQ-012 Port result  output  WIDTH: frame maximum or minimum.
REQ-013 Port result_idx  output  clog2(FRAME_LEN)  position in the frame (0-based) of the winning sample; present only under MMS_ARGIDX_EN.

Function
REQ-014 A sample is accepted on a rising edge with in_valid=1 and in_ready=1. No other input changes state.
REQ-015 FSM states: IDLE, RUN, HOLD.
- IDLE: in_ready=1, out_valid=0.
- RUN: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-016 IDLE, on acceptance:
- Load best = in_data.
- Load best_idx = 0.
- Latch mode = select.
- Set count = 1.
- Go to RUN.
REQ-017 RUN, on acceptance, compare in_data against best.
- Replace best (and best_idx = count) only if in_data is strictly greater (mode=0) or strictly less (mode=1).
- On ties, keep the earlier sample.
REQ-018 RUN: count increments on each acceptance. The acceptance that makes count reach FRAME_LEN goes to HOLD, with the final comparison included.
REQ-019 Latency: out_valid rises on the cycle after the last sample of the frame is accepted.
REQ-020 select changes after the first sample of a frame have no effect until the next frame.
REQ-021 HOLD: result and result_idx stay stable while out_valid=1 and out_ready=0.
REQ-022 HOLD: an edge with out_ready=1 goes to IDLE. The next frame may start one cycle later; no sample is accepted on the handoff edge.
REQ-023 in_valid=0 in RUN leaves all state unchanged; gaps in the input stream are allowed.
REQ-024 In_data in HOLD is ignored; in_ready=0.
REQ-025 Comparison uses SIGNED to interpret both operands. No widening or truncation; result width equals WIDTH.
REQ-026 count is wide enough to hold FRAME_LEN without wrapping. count clears to 0 on return to IDLE.

Reset
REQ-027 Reset, when high on an edge, clears the following and overrides all other activity, including mid-frame and in HOLD:
- FSM to IDLE.
- count = 0.
- best = 0.
- best_idx = 0.
- mode = 0.
REQ-028 After reset: out_valid=0, result=0, result_idx=0, in_ready=1 (from the first cycle after release). A partial frame is discarded.

Configuration
REQ-029 Macro MMS_ARGIDX_EN defined:
- Port result_idx and the best_idx register exist.
- best_idx behaves per REQ-016/017.
REQ-030 Macro MMS_ARGIDX_EN undefined:
- result_idx port and best_idx logic are absent.
- All other behaviour is identical.

Verification
REQ-031 Max frame. Setup: WIDTH=8, FRAME_LEN=4, select=0. Stimulus: 12,200,7,200 back-to-back. Response: one cycle later out_valid=1, result=200, result_idx=1 (tie keeps earlier).
REQ-032 Min frame with select toggling. Setup: select=1 on first sample, then 0. Stimulus: 9,3,3,250. Response: result=3, result_idx=1. The min mode is retained.
REQ-033 Backpressure with gaps. Stimulus: frame 5,9,1,4 with an in_valid=0 gap after sample 2; out_ready=0 for 3 cycles, then 1. Response:
- result=9, result_idx=1, held stable for 3 cycles.
- in_ready=0 throughout HOLD.
- IDLE on the out_ready edge.
REQ-034 Reset mid-frame. Stimulus: accept 250,251, assert reset 1 cycle, then send frame 1,2,3,4 with select=0. Response:
- out_valid=0 after reset.
- Next result=4, result_idx=3; the old samples have no effect.
REQ-035 Signed. Setup: SIGNED=1, WIDTH=8. Stimulus: frame 0x80,0x7F,0xFF,0x01.
- select=0 gives result=0x7F, idx 1.
- select=1 gives result=0x80, idx 0.
REQ-036 Build without MMS_ARGIDX_EN. Stimulus: rerun REQ-031. Response: result=200 and the same timing; no result_idx port.
